// File: rtl/mem_access_unit.sv
// MEM-stage data-memory responder: qualifies load/store requests from the
// decoder, drives a req/ack word memory with byte lanes, extracts and extends
// load data, and stalls the pipeline while an access is outstanding.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic                  memIsSigned,
  input  logic [1:0]            memDataSize,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic [31:0]           rdata,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_be,
  input  logic [31:0]           m_rdata,
  input  logic                  m_ack
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  m_req_q, m_req_d;
  logic                  m_we_q, m_we_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [31:0]           m_wdata_q, m_wdata_d;
  logic [3:0]            m_be_q, m_be_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  misalign_q, misalign_d;
  logic                  bus_err_q, bus_err_d;
  logic                  stall_c;

  logic                  req;
  logic                  mis;
  logic [3:0]            be_c;
  logic [31:0]           wdata_c;
  logic [31:0]           load_c;
  logic [7:0]            lbyte;
  logic [15:0]           lhalf;

  // Request qualification, lane generation and store-data replication
  always_comb begin
    req = memRead | memWrite;
    mis = ((memDataSize == 2'b01) && addr[0]) ||
          ((memDataSize == 2'b10) && (addr[1:0] != 2'b00)) ||
          (memDataSize == 2'b11);
    be_c    = 4'b1111;
    wdata_c = wdata;
    case (memDataSize)
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction using the offset/size/sign captured at request time
  always_comb begin
    case (off_q)
      2'd0:    lbyte = m_rdata[7:0];
      2'd1:    lbyte = m_rdata[15:8];
      2'd2:    lbyte = m_rdata[23:16];
      default: lbyte = m_rdata[31:24];
    endcase
    lhalf = off_q[1] ? m_rdata[31:16] : m_rdata[15:0];
    case (size_q)
      2'b00:   load_c = {{24{sign_q & lbyte[7]}}, lbyte};
      2'b01:   load_c = {{16{sign_q & lhalf[15]}}, lhalf};
      default: load_c = m_rdata;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/BUSY/DONE sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_be_d     = m_be_q;
    size_d     = size_q;
    sign_d     = sign_q;
    off_d      = off_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stall_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && mis) begin
          misalign_d = 1'b1;
        end else if (req) begin
          stall_c   = 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = memWrite;
          m_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
          m_wdata_d = wdata_c;
          m_be_d    = be_c;
          size_d    = memDataSize;
          sign_d    = memIsSigned;
          off_d     = addr[1:0];
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (m_ack) begin
          rdata_d = m_we_q ? 32'd0 : load_c;
          m_req_d = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = 32'd0;
          bus_err_d = 1'b1;
          m_req_d   = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Pipeline advances here; the next request is sampled back in IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_be_q     <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      off_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_be_q     <= m_be_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      off_q      <= off_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Stall is combinational so a new request freezes the pipeline at once
  assign stall    = stall_c & rst;
  assign rdata    = rdata_q;
  assign misalign = misalign_q;
  assign bus_err  = bus_err_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_be     = m_be_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory responder for the control signals produced by the main decoder: memRead, memWrite, memIsSigned, memDataSize.
- Sits in the MEM stage between the ALU address/store-data path and a word-wide data memory that uses a req/ack handshake.
- Generates byte lanes, aligns store data, extracts and extends load data, detects misalignment, and stalls the pipeline for the duration of each access.

Parameters:
- ADDR_WIDTH, 32, byte-address width; data path is fixed at 32 bits.
- TIMEOUT, 16, maximum number of BUSY cycles without m_ack before the access is aborted; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- memRead  in  1  load request from the controller.
- memWrite  in  1  store request from the controller.
- memIsSigned  in  1  1 = sign-extend load data, 0 = zero-extend.
- memDataSize  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- addr  in  ADDR_WIDTH  byte address from the ALU.
- wdata  in  32  store data; the value sits in the low bits.
- stall  out  1  freeze the pipeline while high.
- rdata  out  32  extended load result; valid in the DONE cycle.
- misalign  out  1  one-cycle pulse: misaligned or illegal access was dropped.
- bus_err  out  1  one-cycle pulse: access timed out.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_WIDTH  word-aligned address (addr with bits [1:0] forced to 0).
- m_wdata  out  32  lane-replicated store data.
- m_be  out  4  byte enables; bit i enables bits [8i+7:8i].
- m_rdata  in  32  memory read word.
- m_ack  in  1  memory completion; sampled only while m_req is high.

Behaviour:

Reset (rst=0, asynchronous):
- State goes to IDLE.
- m_req, m_we, m_addr, m_wdata, m_be, rdata, misalign, bus_err all go to 0.
- stall is forced to 0 while rst=0.
- Reset during BUSY abandons the access; a concurrent m_ack is ignored.

Request qualification (IDLE only):
- A request is present when memRead or memWrite is 1.
- If both are 1, the access is treated as a write.
- The access is misaligned when any of these holds:
  - size 01 with addr[0]=1;
  - size 10 with addr[1:0]≠00;
  - size 11 (any address).
- Misaligned or illegal request: no memory access, misalign=1 on the next cycle for one cycle, stall=0, state stays IDLE.

FSM states: IDLE, BUSY, DONE.
- IDLE with a valid request:
  - stall=1 combinationally in the same cycle.
  - At the clock edge, register m_addr, m_we, m_be, m_wdata, size, sign and addr[1:0]; set m_req=1; go to BUSY.
- BUSY:
  - stall=1, m_req=1.
  - On m_ack=1: capture the load result, clear m_req, go to DONE.
  - Otherwise the wait counter increments. When the counter reaches TIMEOUT with no ack: clear m_req, rdata=0, bus_err=1 for one cycle, go to DONE.
  - The wait counter clears on entry to BUSY.
- DONE:
  - stall=0; rdata holds the result; the pipeline advances at this edge.
  - No request is sampled in this cycle.
  - Always goes to IDLE.
- Latency with a zero-wait memory: request cycle, one BUSY cycle, DONE. The pipeline stalls 2 cycles; each wait cycle adds 1.

Byte lanes (little-endian):
- Byte: m_be = 1 << addr[1:0]; m_wdata = wdata[7:0] replicated ×4.
- Half: m_be = addr[1] ? 1100 : 0011; m_wdata = wdata[15:0] replicated ×2.
- Word: m_be = 1111; m_wdata = wdata.

Load extraction:
- Select the byte or half by the registered addr[1:0]; bit 7 or bit 15 is the sign bit when memIsSigned=1, otherwise zero-fill.
- Word loads pass through unchanged.
- Stores leave rdata at 0.
- rdata holds its value until the next DONE or until reset.

Test Plan:
- Word load, addr 0x104, m_ack on the first BUSY cycle, m_rdata=0xDEADBEEF:
  - m_addr=0x104, m_be=1111, m_we=0;
  - stall high for 2 cycles;
  - rdata=0xDEADBEEF in DONE.
- Signed byte load, addr 0x203, m_rdata=0x80xxxxxx → m_be=1000, rdata=0xFFFFFF80. Repeat with memIsSigned=0 → rdata=0x00000080.
- Half store, addr 0x302, wdata=0x1234ABCD → m_addr=0x300, m_be=1100, m_wdata=0xABCDABCD, m_we=1.
- Half load at addr 0x301, and word load at addr 0x102:
  - m_req stays 0;
  - misalign pulses for one cycle each;
  - stall stays 0.
- m_ack held low with TIMEOUT=16:
  - m_req high for 16 cycles, then drops;
  - bus_err pulses once; rdata=0; stall falls in DONE.
- Edge cases:
  - rst driven low mid-BUSY with m_ack=1 in the same cycle → m_req=0 immediately, no DONE.
  - Back-to-back loads → the second request is sampled only in the cycle after DONE.
